// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with a valid/ready output handshake.
// Scans a WIDTH-bit request vector and registers the winning index plus
// its one-hot grant. Arbitration is fixed-priority (direction set by
// MSB_HIGH) or round-robin, chosen per capture by the mode input.
// A result is held until accepted. Back-to-back results are possible
// at one per cycle. grant_cnt counts accepted results and wraps.
module prio_encoder_rr #(
    parameter int WIDTH    = 8,
    parameter bit MSB_HIGH = 1'b1,
    parameter int CNTW     = 16,
    localparam int IDXW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req,
    input  logic              mode,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDXW-1:0]   out_idx,
    output logic [WIDTH-1:0]  out_grant,
    output logic [CNTW-1:0]   grant_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [IDXW-1:0]   out_idx_q, out_idx_d;
    logic [WIDTH-1:0]  out_grant_q, out_grant_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]   grant_cnt_q, grant_cnt_d;
    logic              handshake;
    logic [IDXW-1:0]   win;

    // Winner selection. In round-robin mode the scan starts at ptr and
    // wraps. The loop runs from the farthest candidate back to ptr, so
    // the candidate nearest ptr is written last and wins.
    function automatic logic [IDXW-1:0] pick_winner(
        input logic [WIDTH-1:0] r,
        input logic             m,
        input logic [IDXW-1:0]  p
    );
        logic [IDXW-1:0] w;
        int              j;
        w = '0;
        if (!m) begin
            if (MSB_HIGH) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (r[i]) w = IDXW'(i);
                end
            end else begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (r[i]) w = IDXW'(i);
                end
            end
        end else begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                j = int'(p) + k;
                if (j >= WIDTH) j = j - WIDTH;
                if (r[j]) w = IDXW'(j);
            end
        end
        return w;
    endfunction

    assign handshake = out_valid_q && out_ready;

    // Next-state logic: accept the held result, advance the pointer, capture a new winner.
    always_comb begin
        // NOTE: every _d signal is first given its hold value, so no path
        // through this block leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_grant_d = out_grant_q;
        rr_ptr_d    = rr_ptr_q;
        grant_cnt_d = grant_cnt_q;

        if (handshake) begin
            grant_cnt_d = grant_cnt_q + CNTW'(1);
            if (mode) begin
                rr_ptr_d = (out_idx_q == IDXW'(WIDTH - 1)) ? '0 : out_idx_q + IDXW'(1);
            end
        end

        // The winner uses the pointer as updated by this same handshake.
        win = pick_winner(req, mode, rr_ptr_d);

        if ((state_q == IDLE) || handshake) begin
            if (|req) begin
                out_idx_d   = win;
                out_grant_d = WIDTH'(1) << win;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    // State and output registers. The synchronous reset overrides any held result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_grant_q <= '0;
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_grant_q <= out_grant_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_grant = out_grant_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Testbench for prio_encoder_rr (WIDTH=8, MSB_HIGH=1, CNTW=4).
// The driver steps a reference model at every clock edge and queues each
// captured winner. A monitor on the falling edge compares the DUT
// outputs against the model and the queue, and pops a queue entry on
// each accepted handshake.
module tb_prio_encoder_rr;

  localparam int  WIDTH    = 8;
  localparam bit  MSB_HIGH = 1'b1;
  localparam int  CNTW     = 4;
  localparam int  IDXW     = $clog2(WIDTH);

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  req;
  logic              mode;
  logic              out_ready;
  logic              out_valid;
  logic [IDXW-1:0]   out_idx;
  logic [WIDTH-1:0]  out_grant;
  logic [CNTW-1:0]   grant_cnt;

  prio_encoder_rr #(
    .WIDTH   (WIDTH),
    .MSB_HIGH(MSB_HIGH),
    .CNTW    (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mode     (mode),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .out_grant(out_grant),
    .grant_cnt(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit  started = 1'b0;
  bit  m_valid = 1'b0;
  int  m_idx   = 0;
  int  m_grant = 0;
  int  m_ptr   = 0;
  int  m_cnt   = 0;
  int  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner from the rules: collect the set indices in ascending order, then pick.
  function automatic int ref_win(input logic [WIDTH-1:0] r, input logic md, input int ptr);
    int set_idx[$];
    for (int i = 0; i < WIDTH; i++) if (r[i]) set_idx.push_back(i);
    if (!md) return MSB_HIGH ? set_idx[set_idx.size()-1] : set_idx[0];
    foreach (set_idx[k]) if (set_idx[k] >= ptr) return set_idx[k];
    return set_idx[0];
  endfunction

  task automatic model_step(input logic r, input logic [WIDTH-1:0] rq, input logic md, input logic rdy);
    bit hs;
    started = 1'b1;
    if (r) begin
      m_valid = 1'b0; m_idx = 0; m_grant = 0; m_ptr = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      hs = m_valid && rdy;
      if (hs) begin
        m_cnt = (m_cnt + 1) % (1 << CNTW);
        if (md) m_ptr = (m_idx + 1) % WIDTH;
      end
      if (!m_valid || hs) begin
        if (rq != 0) begin
          m_idx   = ref_win(rq, md, m_ptr);
          m_grant = 1 << m_idx;
          m_valid = 1'b1;
          exp_q.push_back(m_idx);
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive the inputs, step the model at the edge, return 1 time unit after the edge.
  task automatic cycle(input logic r, input logic [WIDTH-1:0] rq, input logic md, input logic rdy);
    rst = r; req = rq; mode = md; out_ready = rdy;
    @(posedge clk);
    model_step(r, rq, md, rdy);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      check("out_idx_model", 32'(out_idx), 32'(m_idx));
      check("out_grant_model", 32'(out_grant), 32'(m_grant));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(out_valid), 32'(0));
        end else begin
          check("sb_idx", 32'(out_idx), 32'(exp_q[0]));
          check("sb_grant", 32'(out_grant), 32'(1 << exp_q[0]));
          if (out_ready && !rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; out_ready = 1'b0;

    // Reset holds outputs at zero, then the first fixed-mode result is index 7.
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_idx", 32'(out_idx), 32'(0));
    check("rst_grant", 32'(out_grant), 32'(0));
    check("rst_cnt", 32'(grant_cnt), 32'(0));
    cycle(1'b0, 8'hFF, 1'b0, 1'b1);
    check("t1_first_idx", 32'(out_idx), 32'(7));
    check("t1_first_valid", 32'(out_valid), 32'(1));

    // Fixed priority: the result is held while out_ready is low.
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'b0010_1001, 1'b0, 1'b0);
    check("t2_idx", 32'(out_idx), 32'(5));
    check("t2_grant", 32'(out_grant), 32'(8'h20));
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h01, 1'b1, 1'b0);
    check("t2_hold_idx", 32'(out_idx), 32'(5));
    check("t2_hold_grant", 32'(out_grant), 32'(8'h20));
    cycle(1'b0, 8'h01, 1'b0, 1'b1);
    check("t2_cnt", 32'(grant_cnt), 32'(1));
    check("t2_next_idx", 32'(out_idx), 32'(0));

    // Round-robin sweep with no bubbles.
    cycle(1'b1, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 8'hFF, 1'b1, 1'b1);
      check("t3_sweep_idx", 32'(out_idx), 32'(k % 8));
      check("t3_sweep_valid", 32'(out_valid), 32'(1));
    end
    check("t3_cnt", 32'(grant_cnt), 32'(9));

    // Round-robin wrap from pointer 6 with two requesters.
    cycle(1'b1, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 8'hFF, 1'b1, 1'b1);
    check("t4_idx5", 32'(out_idx), 32'(5));
    cycle(1'b0, 8'b0000_0011, 1'b1, 1'b1);
    check("t4_wrap_idx0", 32'(out_idx), 32'(0));
    cycle(1'b0, 8'b0000_0011, 1'b1, 1'b1);
    check("t4_idx1", 32'(out_idx), 32'(1));
    cycle(1'b0, 8'b0000_0011, 1'b1, 1'b1);
    check("t4_idx0_again", 32'(out_idx), 32'(0));

    // 17 accepted results wrap the 4-bit counter to 1; the last index is kept after valid falls.
    cycle(1'b1, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h04, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cycle(1'b0, 8'h04, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_cnt_wrap", 32'(grant_cnt), 32'(1));
    check("t5_valid_low", 32'(out_valid), 32'(0));
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("t5_idle_valid", 32'(out_valid), 32'(0));
    end
    check("t5_kept_idx", 32'(out_idx), 32'(2));
    check("t5_kept_grant", 32'(out_grant), 32'(8'h04));

    // Reset in HOLD with the pointer at 3.
    cycle(1'b1, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'hFF, 1'b1, 1'b1);
    cycle(1'b0, 8'hFF, 1'b1, 1'b0);
    check("t6_pre_idx", 32'(out_idx), 32'(3));
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    check("t6_rst_valid", 32'(out_valid), 32'(0));
    check("t6_rst_cnt", 32'(grant_cnt), 32'(0));
    cycle(1'b0, 8'hFF, 1'b1, 1'b1);
    check("t6_ptr_cleared", 32'(out_idx), 32'(0));

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      logic [WIDTH-1:0] rq;
      rq = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
      cycle(($urandom_range(0, 60) == 0), rq, 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
